// File: rtl/spi_flash_pkg.sv
// Shared types and opcode helpers for the SPI flash command scheduler.
// Opcodes follow the common 25-series serial flash command set.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WREN_GO   = 3'd1,
    ST_WREN_WAIT = 3'd2,
    ST_CMD_GO    = 3'd3,
    ST_CMD_WAIT  = 3'd4,
    ST_POLL_GO   = 3'd5,
    ST_POLL_WAIT = 3'd6,
    ST_RESP      = 3'd7
  } state_t;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_BE   = 8'hD8;
  localparam logic [7:0] OP_CE   = 8'hC7;
  localparam logic [7:0] OP_WRSR = 8'h01;

  // Write-class commands need a WREN before and a WIP poll after.
  function automatic logic is_write_class(input logic [7:0] op);
    return (op == OP_PP) || (op == OP_SE) || (op == OP_BE) ||
           (op == OP_CE) || (op == OP_WRSR);
  endfunction

  function automatic logic has_addr(input logic [7:0] op);
    return (op == OP_PP) || (op == OP_READ) || (op == OP_SE) || (op == OP_BE);
  endfunction

endpackage

// File: rtl/spi_cmd_scheduler_if.sv
// Bundle of requester, response and shift-engine signals of the scheduler.
// rq_valid/rq_ready: a request transfers on a cycle where both bits are high;
// the requester holds rq_valid and its opcode/addr stable until that cycle.
interface spi_cmd_scheduler_if;
  import spi_flash_pkg::*;

  logic [1:0]  rq_valid;
  logic [1:0]  rq_ready;
  logic [7:0]  rq_opcode0;
  logic [7:0]  rq_opcode1;
  logic [23:0] rq_addr0;
  logic [23:0] rq_addr1;

  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_data;

  logic        eng_start;
  logic [7:0]  eng_opcode;
  logic [23:0] eng_addr;
  logic        eng_has_addr;
  logic        eng_done;
  logic [7:0]  eng_rdata;

  logic        busy;
  state_t      dbg_state;

  modport master (
    input  rq_valid, rq_opcode0, rq_opcode1, rq_addr0, rq_addr1,
    input  eng_done, eng_rdata,
    output rq_ready, rsp_valid, rsp_err, rsp_data,
    output eng_start, eng_opcode, eng_addr, eng_has_addr,
    output busy, dbg_state
  );

  modport slave (
    output rq_valid, rq_opcode0, rq_opcode1, rq_addr0, rq_addr1,
    output eng_done, eng_rdata,
    input  rq_ready, rsp_valid, rsp_err, rsp_data,
    input  eng_start, eng_opcode, eng_addr, eng_has_addr,
    input  busy, dbg_state
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant register moves only when the
// owner of a command finishes, so a tie goes to whoever was not served last.
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic       grant_idx,
  output logic       grant_any
);

  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= upd_idx;
    end
  end

  always_comb begin
    grant_any = |req;
    if (&req) begin
      grant_idx = ~last_q;
    end else begin
      grant_idx = req[1];
    end
  end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Serialises flash commands from two requesters onto one SPI shift engine,
// wrapping write-class commands in WREN + status polling until WIP clears.
module spi_cmd_scheduler
  import spi_flash_pkg::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'd1000,
  parameter int          WIP_BIT    = 0
) (
  input logic                 ACLK,
  input logic                 ARESETn,
  spi_cmd_scheduler_if.master bus
);

  state_t      state, state_next;
  logic [7:0]  op_q;
  logic [23:0] addr_q;
  logic        gnt_q;
  logic        err_q;
  logic [7:0]  data_q;
  logic [15:0] poll_q;

  logic        gnt_idx;
  logic        gnt_any;
  logic [7:0]  sel_op;
  logic [23:0] sel_addr;
  logic [15:0] poll_next;
  logic        wip;
  logic        timeout;

  spi_rr_arbiter u_arb (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .req       (bus.rq_valid),
    .update    (state == ST_RESP),
    .upd_idx   (gnt_q),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign sel_op    = gnt_idx ? bus.rq_opcode1 : bus.rq_opcode0;
  assign sel_addr  = gnt_idx ? bus.rq_addr1   : bus.rq_addr0;
  assign poll_next = poll_q + 16'd1;
  assign wip       = bus.eng_rdata[WIP_BIT];
  assign timeout   = (poll_next == POLL_LIMIT);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // eng_done only matters in the *_WAIT states; elsewhere it is ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (gnt_any) begin
          state_next = is_write_class(sel_op) ? ST_WREN_GO : ST_CMD_GO;
        end
      end
      ST_WREN_GO:   state_next = ST_WREN_WAIT;
      ST_WREN_WAIT: if (bus.eng_done) state_next = ST_CMD_GO;
      ST_CMD_GO:    state_next = ST_CMD_WAIT;
      ST_CMD_WAIT: begin
        if (bus.eng_done) begin
          state_next = is_write_class(op_q) ? ST_POLL_GO : ST_RESP;
        end
      end
      ST_POLL_GO:   state_next = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (bus.eng_done) begin
          if (!wip || timeout) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_POLL_GO;
          end
        end
      end
      ST_RESP:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state != ST_IDLE);
    bus.dbg_state    = state;
    bus.eng_start    = (state == ST_WREN_GO) || (state == ST_CMD_GO) ||
                       (state == ST_POLL_GO);
    bus.rq_ready     = 2'b00;
    bus.rsp_valid    = 2'b00;
    bus.rsp_err      = err_q;
    bus.rsp_data     = data_q;
    bus.eng_opcode   = 8'h00;
    bus.eng_addr     = 24'h000000;
    bus.eng_has_addr = 1'b0;
    // Gating with ARESETn keeps rq_ready low while reset is held.
    if ((state == ST_IDLE) && ARESETn && gnt_any) begin
      bus.rq_ready = gnt_idx ? 2'b10 : 2'b01;
    end
    if (state == ST_RESP) begin
      bus.rsp_valid = gnt_q ? 2'b10 : 2'b01;
    end
    case (state)
      ST_WREN_GO, ST_WREN_WAIT: begin
        bus.eng_opcode = OP_WREN;
      end
      ST_CMD_GO, ST_CMD_WAIT: begin
        bus.eng_opcode   = op_q;
        bus.eng_has_addr = has_addr(op_q);
        bus.eng_addr     = has_addr(op_q) ? addr_q : 24'h000000;
      end
      ST_POLL_GO, ST_POLL_WAIT: begin
        bus.eng_opcode = OP_RDSR;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      op_q   <= 8'h00;
      addr_q <= 24'h000000;
      gnt_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= 8'h00;
      poll_q <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            op_q   <= sel_op;
            addr_q <= sel_addr;
            gnt_q  <= gnt_idx;
            err_q  <= 1'b0;
          end
        end
        ST_CMD_WAIT: begin
          if (bus.eng_done) begin
            data_q <= bus.eng_rdata;
            poll_q <= 16'd0;
          end
        end
        ST_POLL_WAIT: begin
          if (bus.eng_done && wip) begin
            poll_q <= poll_next;
            if (timeout) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler: a scripted shift-engine model plus an
// expected-command queue checked on every eng_start.
module tb_spi_cmd_scheduler;
  import spi_flash_pkg::*;

  logic ACLK;
  logic ARESETn;

  spi_cmd_scheduler_if bus ();

  spi_cmd_scheduler #(
    .POLL_LIMIT (16'd4),
    .WIP_BIT    (0)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  rd_q[$];
  int eng_delay  = 2;
  int spur_cnt   = 0;
  int ready_viol = 0;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] cmd(input logic [7:0] op, input logic [23:0] a, input logic ha);
    return {ha, a, op};
  endfunction

  // ---------------- shift-engine model ----------------
  initial begin : engine
    int cd;
    int spur_seen;
    cd = 0;
    spur_seen = 0;
    bus.eng_done  = 1'b0;
    bus.eng_rdata = 8'h00;
    forever begin
      @(posedge ACLK);
      #1;
      bus.eng_done = 1'b0;
      if (!ARESETn) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.eng_done  = 1'b1;
            bus.eng_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
          end
        end
        if (spur_cnt != spur_seen) begin
          spur_seen     = spur_cnt;
          bus.eng_done  = 1'b1;
          bus.eng_rdata = 8'hEE;
        end
        if (bus.eng_start) begin
          check_eq("eng_q_nonempty", 40'(exp_q.size() != 0), 40'd1);
          if (exp_q.size() != 0) begin
            check_eq("eng_cmd", 40'({bus.eng_has_addr, bus.eng_addr, bus.eng_opcode}),
                     40'(exp_q.pop_front()));
          end
          cd = eng_delay;
        end
      end
    end
  end

  initial begin : ready_mon
    forever begin
      @(negedge ACLK);
      if (bus.busy && (bus.rq_ready != 2'b00)) ready_viol++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input int idx, input logic [7:0] op, input logic [23:0] a, input bit spur);
    bit ok;
    @(negedge ACLK);
    if (idx == 0) begin
      bus.rq_opcode0 = op;
      bus.rq_addr0   = a;
    end else begin
      bus.rq_opcode1 = op;
      bus.rq_addr1   = a;
    end
    bus.rq_valid[idx] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (bus.rq_ready[idx]) ok = 1'b1;
      else @(negedge ACLK);
    end
    if (ok && spur) spur_cnt++;
    check_eq("req_accept", 40'(ok), 40'd1);
    @(negedge ACLK);
    bus.rq_valid[idx] = 1'b0;
    check_eq("start_latency", 40'(bus.eng_start), 40'd1);
  endtask

  task automatic wait_rsp(input int limit, output int cyc, output logic [1:0] v,
                          output logic e, output logic [7:0] d);
    cyc = 0;
    v   = 2'b00;
    while (v == 2'b00 && cyc < limit) begin
      @(negedge ACLK);
      cyc++;
      v = bus.rsp_valid;
    end
    e = bus.rsp_err;
    d = bus.rsp_data;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int cyc;
    logic [1:0] v;
    logic e;
    logic [7:0] d;
    bit found;

    ARESETn        = 1'b0;
    bus.rq_valid   = 2'b11;
    bus.rq_opcode0 = 8'h03;
    bus.rq_opcode1 = 8'h03;
    bus.rq_addr0   = 24'h0;
    bus.rq_addr1   = 24'h0;
    repeat (2) @(negedge ACLK);
    check_eq("rst_busy",      40'(bus.busy), 40'd0);
    check_eq("rst_rq_ready",  40'(bus.rq_ready), 40'd0);
    check_eq("rst_eng_start", 40'(bus.eng_start), 40'd0);
    check_eq("rst_eng_cmd",   40'({bus.eng_has_addr, bus.eng_addr, bus.eng_opcode}), 40'd0);
    check_eq("rst_rsp",       40'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 40'd0);
    check_eq("rst_state",     40'(bus.dbg_state), 40'(ST_IDLE));
    bus.rq_valid = 2'b00;
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    // Spurious eng_done while idle.
    spur_cnt++;
    repeat (3) @(negedge ACLK);
    check_eq("idle_spur_busy",  40'(bus.busy), 40'd0);
    check_eq("idle_spur_state", 40'(bus.dbg_state), 40'(ST_IDLE));
    check_eq("idle_spur_data",  40'(bus.rsp_data), 40'd0);

    // Both requesters held high: grants alternate 0,1,0,1, five cycles apart.
    eng_delay = 2;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(cmd(8'h03, (k % 2 == 0) ? 24'h000100 : 24'h000200, 1'b1));
      rd_q.push_back(8'h10 + 8'(k));
    end
    @(negedge ACLK);
    bus.rq_opcode0 = 8'h03; bus.rq_addr0 = 24'h000100;
    bus.rq_opcode1 = 8'h03; bus.rq_addr1 = 24'h000200;
    bus.rq_valid   = 2'b11;
    #1;
    check_eq("rr_first_ready", 40'(bus.rq_ready), 40'd1);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(20, cyc, v, e, d);
      check_eq("rr_grant", 40'(v), (k % 2 == 0) ? 40'd1 : 40'd2);
      check_eq("rr_data",  40'(d), 40'(8'h10 + 8'(k)));
      if (k > 0) check_eq("rr_gap", 40'(cyc), 40'd5);
      if (k == 3) bus.rq_valid = 2'b00;
    end
    check_eq("rr_drained", 40'(exp_q.size()), 40'd0);

    // Plain read: one engine command, data returned at done+1.
    eng_delay = 20;
    exp_q.push_back(cmd(8'h03, 24'h001000, 1'b1));
    rd_q.push_back(8'hA5);
    send_req(0, 8'h03, 24'h001000, 1'b0);
    wait_rsp(40, cyc, v, e, d);
    check_eq("rd_valid",   40'(v), 40'd1);
    check_eq("rd_err",     40'(e), 40'd0);
    check_eq("rd_data",    40'(d), 40'hA5);
    check_eq("rd_latency", 40'(cyc), 40'd21);
    check_eq("rd_drained", 40'(exp_q.size()), 40'd0);

    // Sector erase: WREN, SE, then RDSR until WIP clears.
    eng_delay = 3;
    exp_q.push_back(cmd(8'h06, 24'h0, 1'b0));
    exp_q.push_back(cmd(8'h20, 24'h010000, 1'b1));
    repeat (3) exp_q.push_back(cmd(8'h05, 24'h0, 1'b0));
    rd_q.push_back(8'h00); rd_q.push_back(8'h5A);
    rd_q.push_back(8'h01); rd_q.push_back(8'h01); rd_q.push_back(8'h00);
    send_req(1, 8'h20, 24'h010000, 1'b0);
    wait_rsp(100, cyc, v, e, d);
    check_eq("se_valid",   40'(v), 40'd2);
    check_eq("se_err",     40'(e), 40'd0);
    check_eq("se_data",    40'(d), 40'h5A);
    check_eq("se_drained", 40'(exp_q.size() + rd_q.size()), 40'd0);

    // Chip erase that never finishes: POLL_LIMIT=4 RDSRs then error.
    exp_q.push_back(cmd(8'h06, 24'h0, 1'b0));
    exp_q.push_back(cmd(8'hC7, 24'h0, 1'b0));
    repeat (4) exp_q.push_back(cmd(8'h05, 24'h0, 1'b0));
    rd_q.push_back(8'h00); rd_q.push_back(8'h3C);
    repeat (4) rd_q.push_back(8'h01);
    send_req(0, 8'hC7, 24'h0, 1'b0);
    wait_rsp(100, cyc, v, e, d);
    check_eq("ce_valid",   40'(v), 40'd1);
    check_eq("ce_err",     40'(e), 40'd1);
    check_eq("ce_data",    40'(d), 40'h3C);
    check_eq("ce_drained", 40'(exp_q.size()), 40'd0);

    // Reset while polling after a page program.
    eng_delay = 30;
    exp_q.push_back(cmd(8'h06, 24'h0, 1'b0));
    exp_q.push_back(cmd(8'h02, 24'h000AAA, 1'b1));
    exp_q.push_back(cmd(8'h05, 24'h0, 1'b0));
    rd_q.push_back(8'h00); rd_q.push_back(8'h11); rd_q.push_back(8'h01);
    send_req(0, 8'h02, 24'h000AAA, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge ACLK);
      if (bus.dbg_state == ST_POLL_WAIT) found = 1'b1;
    end
    check_eq("ab_reach_poll", 40'(found), 40'd1);
    ARESETn = 1'b0;
    #1;
    check_eq("ab_busy",      40'(bus.busy), 40'd0);
    check_eq("ab_eng_start", 40'(bus.eng_start), 40'd0);
    check_eq("ab_eng_cmd",   40'({bus.eng_has_addr, bus.eng_addr, bus.eng_opcode}), 40'd0);
    check_eq("ab_rsp",       40'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 40'd0);
    check_eq("ab_rq_ready",  40'(bus.rq_ready), 40'd0);
    check_eq("ab_state",     40'(bus.dbg_state), 40'(ST_IDLE));
    @(negedge ACLK);
    ARESETn = 1'b1;
    exp_q.delete();
    rd_q.delete();
    wait_rsp(10, cyc, v, e, d);
    check_eq("ab_no_rsp", 40'(v), 40'd0);

    // After reset, requester 0 wins the first tie.
    eng_delay = 2;
    exp_q.push_back(cmd(8'h03, 24'h123456, 1'b1));
    rd_q.push_back(8'h77);
    @(negedge ACLK);
    bus.rq_opcode0 = 8'h03; bus.rq_addr0 = 24'h123456;
    bus.rq_opcode1 = 8'h03; bus.rq_addr1 = 24'h654321;
    bus.rq_valid   = 2'b11;
    #1;
    check_eq("post_rst_tie", 40'(bus.rq_ready), 40'd1);
    @(negedge ACLK);
    bus.rq_valid = 2'b00;
    wait_rsp(20, cyc, v, e, d);
    check_eq("post_rst_valid", 40'(v), 40'd1);
    check_eq("post_rst_rsp",   40'({e, d}), 40'h077);
    check_eq("post_rst_drain", 40'(exp_q.size()), 40'd0);

    // Spurious eng_done during CMD_GO must not shorten the command.
    eng_delay = 4;
    exp_q.push_back(cmd(8'h03, 24'h000010, 1'b1));
    rd_q.push_back(8'h42);
    send_req(1, 8'h03, 24'h000010, 1'b1);
    wait_rsp(20, cyc, v, e, d);
    check_eq("go_spur_valid",   40'(v), 40'd2);
    check_eq("go_spur_data",    40'(d), 40'h42);
    check_eq("go_spur_latency", 40'(cyc), 40'd5);
    check_eq("go_spur_drained", 40'(exp_q.size()), 40'd0);

    repeat (3) @(negedge ACLK);
    check_eq("ready_while_busy", 40'(ready_viol), 40'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_scheduler.md
SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 Parameter POLL_LIMIT, default 16'd1000, maximum status-poll iterations before timeout.
REQ-002 Parameter WIP_BIT, default 0, status-register bit index of write-in-progress.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 rq_valid  in  2  per-requester command request (index 0, 1).
REQ-006 rq_ready  out  2  per-requester accept strobe.
REQ-007 rq_opcode0/rq_opcode1  in  8 each  SPI opcode.
REQ-008 rq_addr0/rq_addr1  in  24 each  flash address.
REQ-009 rsp_valid  out  2  one-cycle completion pulse per requester.
REQ-010 rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-011 rsp_data  out  8  last byte returned by command, qualified by rsp_valid.
REQ-012 eng_start  out  1  one-cycle start pulse to SPI shift engine.
REQ-013 eng_opcode  out  8, eng_addr  out  24, eng_has_addr  out  1  engine command fields, stable from eng_start until eng_done.
REQ-014 eng_done  in  1  one-cycle engine completion pulse; eng_rdata  in  8  byte read by engine.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, WREN_GO, WREN_WAIT, CMD_GO, CMD_WAIT, POLL_GO, POLL_WAIT, RESP.
REQ-017 IDLE: if any rq_valid, grant round-robin (both valid -> requester not granted last; single valid -> that one); rq_ready[g] high for exactly that cycle; latch opcode, addr, grant index.
REQ-018 rq_ready SHALL be 0 outside IDLE; no request accepted while busy.
REQ-019 Write-class opcodes (0x02, 0x20, 0xD8, 0xC7, 0x01) go IDLE -> WREN_GO; others IDLE -> CMD_GO.
REQ-020 Any *_GO state: eng_start=1 for one cycle, then next state *_WAIT.
REQ-021 WREN_GO issues opcode 0x06, eng_has_addr=0; WREN_WAIT -> CMD_GO on eng_done.
REQ-022 CMD_GO issues latched opcode; eng_has_addr=1 for 0x02, 0x03, 0x20, 0xD8, else 0.
REQ-023 CMD_WAIT on eng_done: capture eng_rdata into rsp_data; write-class -> POLL_GO with poll counter cleared; else -> RESP.
REQ-024 POLL_GO issues 0x05, no address; POLL_WAIT on eng_done: eng_rdata[WIP_BIT]=0 -> RESP, err=0.
REQ-025 eng_rdata[WIP_BIT]=1: counter+1; counter+1==POLL_LIMIT -> RESP with err=1; else -> POLL_GO next cycle.
REQ-026 Poll counter 16 bits, saturating never required (bounded by POLL_LIMIT).
REQ-027 RESP: rsp_valid[grant]=1 one cycle, rsp_err/rsp_data valid same cycle; update last-grant; -> IDLE.
REQ-028 Latency: accept at cycle T, first eng_start at T+1; eng_done at D -> next eng_start at D+1 or rsp_valid at D+1.
REQ-029 eng_done outside *_WAIT states SHALL be ignored.
REQ-030 eng_start and eng_done in same cycle cannot occur; eng_done in a *_GO cycle is ignored.
REQ-031 New rq_valid arriving during RESP is accepted in the following IDLE cycle, earliest.

Reset
REQ-032 ARESETn low: state IDLE, eng_start=0, rq_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, eng_opcode=0, eng_addr=0, eng_has_addr=0, busy=0, poll counter=0, last-grant=1 (requester 0 wins first tie).
REQ-033 Reset mid-operation aborts the sequence; no rsp_valid issued for the aborted command.

Structure
REQ-034 Shared package spi_flash_pkg holds: state enum, opcode localparams (WREN, RDSR, PP, READ, SE, BE, CE, WRSR), function is_write_class(opcode), function has_addr(opcode).
REQ-035 One sub-module natural: spi_rr_arbiter (2-way round-robin grant, last-grant register).

Verification
REQ-036 Req0 opcode 0x03 addr 0x001000, engine done after 20 cycles rdata 0xA5 -> single eng_start (0x03, has_addr=1), rsp_valid[0] with rsp_data 0xA5, err=0.
REQ-037 Req1 opcode 0x20 addr 0x010000, polls return 0x01,0x01,0x00 -> engine sequence 0x06, 0x20, 0x05 x3, rsp_valid[1], err=0.
REQ-038 Both rq_valid held high with 0x03 each -> grants alternate 0,1,0,1; rq_ready never high while busy.
REQ-039 POLL_LIMIT=4, opcode 0xC7, status always 0x01 -> exactly 4 RDSR issues, rsp_err=1.
REQ-040 ARESETn pulsed low during POLL_WAIT -> all outputs at reset values immediately, no rsp_valid, next request served normally.
REQ-041 Spurious eng_done in IDLE and in CMD_GO -> no state change, no extra eng_start.
